// File: rtl/shot_pkg.sv
// Shared types and constants for the shot scheduler and its slot FSMs.
package shot_pkg;

  localparam int COORD_W = 11;

  typedef enum logic [1:0] {
    SLOT_IDLE   = 2'd0,
    SLOT_ARM    = 2'd1,
    SLOT_ACTIVE = 2'd2
  } slot_state_e;

endpackage

// File: rtl/shot_slot_fsm.sv
// One shot slot: IDLE -> ARM (origin latched) -> ACTIVE (en high) -> IDLE.
// ARM holds en low until a move tick so the shot can load its origin.
module shot_slot_fsm
  import shot_pkg::*;
#(
  parameter int  NUM_REQ   = 8,
  parameter int  MAX_TICKS = 600,
  localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int LIFE_W    = $clog2(MAX_TICKS + 1)
) (
  input  logic               s_clk,
  input  logic               rst,
  input  logic               move_tick,
  input  logic               grant,
  input  logic [ID_W-1:0]    grant_id,
  input  logic [COORD_W-1:0] grant_x,
  input  logic [COORD_W-1:0] grant_y,
  input  logic               done,
  output logic               busy,
  output logic               busy_next,
  output logic               en,
  output logic [ID_W-1:0]    owner,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y
);

  slot_state_e       state;
  slot_state_e       state_next;
  logic [LIFE_W-1:0] life_cnt;
  logic              life_out;

  // The tick that brings the counter to MAX_TICKS retires the slot.
  assign life_out = move_tick && (life_cnt == LIFE_W'(MAX_TICKS - 1));

  // State register.
  always_ff @(posedge s_clk) begin
    // NOTE: non-blocking so every register samples pre-edge values, whatever the block order.
    if (rst) state <= SLOT_IDLE;
    else     state <= state_next;
  end

  // Next-state decision.
  always_comb begin
    // NOTE: default assignment first; any path that skips it would infer a latch.
    state_next = state;
    case (state)
      SLOT_IDLE:   if (grant)             state_next = SLOT_ARM;
      SLOT_ARM:    if (move_tick)         state_next = SLOT_ACTIVE;
      SLOT_ACTIVE: if (done || life_out)  state_next = SLOT_IDLE;
      default:                            state_next = SLOT_IDLE;
    endcase
  end

  // Outputs decoded from the current and next state.
  always_comb begin
    en        = (state == SLOT_ACTIVE);
    busy      = (state != SLOT_IDLE);
    busy_next = (state_next != SLOT_IDLE);
  end

  // Owner/origin capture on grant, life counter while in flight.
  always_ff @(posedge s_clk) begin
    if (rst) begin
      owner    <= '0;
      x        <= '0;
      y        <= '0;
      life_cnt <= '0;
    end else begin
      if (grant && state == SLOT_IDLE) begin
        owner <= grant_id;
        x     <= grant_x;
        y     <= grant_y;
      end
      if (state == SLOT_ARM && move_tick)         life_cnt <= '0;
      else if (state == SLOT_ACTIVE && move_tick) life_cnt <= life_cnt + LIFE_W'(1);
    end
  end

endmodule

// File: rtl/shot_scheduler.sv
// Allocates shot slots to fire requesters: round-robin arbiter with a
// one-live-shot-per-requester rule and a post-grant cooldown in move ticks.
module shot_scheduler
  import shot_pkg::*;
#(
  parameter int NUM_SLOTS = 4,
  parameter int NUM_REQ   = 8,
  parameter int COOLDOWN  = 3,
  parameter int MAX_TICKS = 600
) (
  input  logic                         s_clk,
  input  logic                         rst,
  input  logic                         move_tick,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*COORD_W-1:0]   req_x,
  input  logic [NUM_REQ*COORD_W-1:0]   req_y,
  input  logic [NUM_SLOTS-1:0]         slot_done,
  output logic [NUM_REQ-1:0]           gnt,
  output logic [NUM_SLOTS-1:0]         slot_en,
  output logic [NUM_SLOTS*COORD_W-1:0] slot_x,
  output logic [NUM_SLOTS*COORD_W-1:0] slot_y,
  output logic [3:0]                   live_cnt
);

  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int CD_W   = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    win_id;
  logic [ID_W:0]      cand_sum;
  logic [ID_W-1:0]    cand;
  logic               win_found;
  logic [CD_W-1:0]    cd_cnt;
  logic [NUM_SLOTS-1:0] slot_busy;
  logic [NUM_SLOTS-1:0] slot_busy_next;
  logic [NUM_SLOTS-1:0] slot_grant;
  logic [ID_W-1:0]    slot_owner [NUM_SLOTS];
  logic [NUM_REQ-1:0] owns;
  logic               free_found;
  logic [SLOT_W-1:0]  free_idx;
  logic               grant_now;
  logic [3:0]         live_next;
  logic [COORD_W-1:0] win_x;
  logic [COORD_W-1:0] win_y;

  // Which requesters hold a live slot, and the lowest-index idle slot.
  always_comb begin
    owns       = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
      if (!slot_busy[s]) begin
        free_found = 1'b1;
        free_idx   = SLOT_W'(s);
      end else begin
        owns[slot_owner[s]] = 1'b1;
      end
    end
  end

  // Round-robin search starting at the pointer, skipping requesters with a live shot.
  always_comb begin
    win_found = 1'b0;
    win_id    = ptr;
    cand_sum  = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_sum = {1'b0, ptr} + (ID_W + 1)'(k);
      if (cand_sum >= (ID_W + 1)'(NUM_REQ)) cand_sum = cand_sum - (ID_W + 1)'(NUM_REQ);
      cand = cand_sum[ID_W-1:0];
      if (!win_found && req[cand] && !owns[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  assign grant_now = free_found && (cd_cnt == '0) && win_found;
  assign win_x     = req_x[win_id*COORD_W +: COORD_W];
  assign win_y     = req_y[win_id*COORD_W +: COORD_W];

  // Steer the grant to the chosen slot and count slots busy after this edge.
  always_comb begin
    slot_grant = '0;
    if (grant_now) slot_grant[free_idx] = 1'b1;
    live_next = '0;
    for (int s = 0; s < NUM_SLOTS; s++) live_next = live_next + 4'(slot_busy_next[s]);
  end

  // Arbiter state: grant pulse, pointer, cooldown and live count.
  always_ff @(posedge s_clk) begin
    if (rst) begin
      gnt      <= '0;
      ptr      <= '0;
      cd_cnt   <= '0;
      live_cnt <= '0;
    end else begin
      gnt      <= '0;
      live_cnt <= live_next;
      if (grant_now) begin
        gnt[win_id] <= 1'b1;
        ptr         <= (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + ID_W'(1);
        cd_cnt      <= CD_W'(COOLDOWN);
      end else if (move_tick && cd_cnt != '0) begin
        cd_cnt <= cd_cnt - CD_W'(1);
      end
    end
  end

  for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
    shot_slot_fsm #(
      .NUM_REQ   (NUM_REQ),
      .MAX_TICKS (MAX_TICKS)
    ) u_slot (
      .s_clk     (s_clk),
      .rst       (rst),
      .move_tick (move_tick),
      .grant     (slot_grant[s]),
      .grant_id  (win_id),
      .grant_x   (win_x),
      .grant_y   (win_y),
      .done      (slot_done[s]),
      .busy      (slot_busy[s]),
      .busy_next (slot_busy_next[s]),
      .en        (slot_en[s]),
      .owner     (slot_owner[s]),
      .x         (slot_x[s*COORD_W +: COORD_W]),
      .y         (slot_y[s*COORD_W +: COORD_W])
    );
  end

endmodule

// File: tb/tb_shot_scheduler.sv
// Bench for shot_scheduler: two instances (cooldown 3 and cooldown 0),
// grant scoreboard per instance plus cycle-exact checks.
module tb_shot_scheduler;

  logic        clk = 1'b0;
  logic        rst_a, tick_a, rst_b, tick_b;
  logic [7:0]  req_a, req_b, gnt_a, gnt_b;
  logic [87:0] rx_a, ry_a, rx_b, ry_b;
  logic [3:0]  done_a, done_b, en_a, en_b, live_a, live_b;
  logic [43:0] sx_a, sy_a, sx_b, sy_b;

  int n_total = 0;
  int n_bad   = 0;
  logic [7:0] q_a [$];
  logic [7:0] q_b [$];

  always #5 clk = ~clk;

  shot_scheduler #(.NUM_SLOTS(4), .NUM_REQ(8), .COOLDOWN(3), .MAX_TICKS(600)) u_a (
    .s_clk(clk), .rst(rst_a), .move_tick(tick_a), .req(req_a), .req_x(rx_a), .req_y(ry_a),
    .slot_done(done_a), .gnt(gnt_a), .slot_en(en_a), .slot_x(sx_a), .slot_y(sy_a),
    .live_cnt(live_a)
  );

  shot_scheduler #(.NUM_SLOTS(4), .NUM_REQ(8), .COOLDOWN(0), .MAX_TICKS(600)) u_b (
    .s_clk(clk), .rst(rst_b), .move_tick(tick_b), .req(req_b), .req_x(rx_b), .req_y(ry_b),
    .slot_done(done_b), .gnt(gnt_b), .slot_en(en_b), .slot_x(sx_b), .slot_y(sy_b),
    .live_cnt(live_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick_pulses_a(input int n);
    for (int i = 0; i < n; i++) begin
      tick_a = 1'b1; cyc();
      tick_a = 1'b0; cyc();
    end
  endtask

  // Scoreboards: every grant pulse must match the next expected grant.
  always @(negedge clk) begin
    logic [7:0] exp;
    if (gnt_a != 8'h00) begin
      if (q_a.size() == 0) check("a_sb_unexpected", 32'(gnt_a), 32'h0);
      else begin exp = q_a.pop_front(); check("a_sb_gnt", 32'(gnt_a), 32'(exp)); end
    end
    if (gnt_b != 8'h00) begin
      if (q_b.size() == 0) check("b_sb_unexpected", 32'(gnt_b), 32'h0);
      else begin exp = q_b.pop_front(); check("b_sb_gnt", 32'(gnt_b), 32'(exp)); end
    end
  end

  initial begin
    rst_a = 1'b1; tick_a = 1'b0; req_a = '0; rx_a = '0; ry_a = '0; done_a = '0;
    rst_b = 1'b1; tick_b = 1'b0; req_b = '0; rx_b = '0; ry_b = '0; done_b = '0;
    cyc(2);

    // Reset state
    check("a_rst_gnt", 32'(gnt_a), 0);
    check("a_rst_en", 32'(en_a), 0);
    check("a_rst_live", 32'(live_a), 0);
    check("a_rst_x", 32'(sx_a), 0);
    check("a_rst_y", 32'(sy_a), 0);
    check("b_rst_live", 32'(live_b), 0);
    rst_a = 1'b0;
    cyc();

    // First grant to the player
    req_a[0] = 1'b1; rx_a[10:0] = 11'd320; ry_a[10:0] = 11'd440;
    q_a.push_back(8'h01);
    cyc();
    check("a_gnt0_t1", 32'(gnt_a), 32'h01);
    check("a_arm_live", 32'(live_a), 1);
    check("a_arm_en", 32'(en_a), 0);
    cyc();
    check("a_gnt_pulse", 32'(gnt_a), 0);
    check("a_arm_en2", 32'(en_a), 0);
    tick_a = 1'b1;
    cyc();
    tick_a = 1'b0;
    check("a_en_rise", 32'(en_a), 32'h1);
    check("a_slot0_x", 32'(sx_a[10:0]), 320);
    check("a_slot0_y", 32'(sy_a[10:0]), 440);

    // Held request, no re-grant until retire
    tick_pulses_a(3);
    check("a_no_regnt", 32'(gnt_a), 0);
    done_a = 4'b0001;
    cyc();
    done_a = 4'b0000;
    check("a_done_en", 32'(en_a), 0);
    check("a_done_live", 32'(live_a), 0);
    q_a.push_back(8'h01);
    cyc();
    check("a_regnt_d2", 32'(gnt_a), 32'h01);
    check("a_regnt_live", 32'(live_a), 1);

    // slot_done during ARM is ignored
    done_a = 4'b0001;
    cyc();
    done_a = 4'b0000;
    check("a_arm_done_ignored", 32'(live_a), 1);
    tick_a = 1'b1;
    cyc();
    tick_a = 1'b0;
    check("a_active_after_arm", 32'(en_a), 32'h1);
    tick_pulses_a(2);

    // Cooldown of three move ticks between grants
    req_a[1] = 1'b1; rx_a[21:11] = 11'd100; ry_a[21:11] = 11'd200;
    q_a.push_back(8'h02);
    cyc();
    check("a_gnt1", 32'(gnt_a), 32'h02);
    tick_a = 1'b1;
    req_a[2] = 1'b1; rx_a[32:22] = 11'd300; ry_a[32:22] = 11'd400;
    q_a.push_back(8'h04);
    cyc();
    tick_a = 1'b0;
    check("a_cd_hold1", 32'(gnt_a), 0);
    cyc();
    tick_a = 1'b1;
    cyc();
    tick_a = 1'b0;
    cyc();
    tick_a = 1'b1;
    check("a_cd_hold2", 32'(gnt_a), 0);
    cyc();
    tick_a = 1'b0;
    check("a_cd_hold3", 32'(gnt_a), 0);
    cyc();
    check("a_cd_release", 32'(gnt_a), 32'h04);
    check("a_slot2_x", 32'(sx_a[32:22]), 300);

    // Lifetime timeout on slot 2
    req_a = '0;
    done_a = 4'b0011;
    cyc();
    done_a = 4'b0000;
    check("a_live_one", 32'(live_a), 1);
    tick_a = 1'b1;
    cyc();
    tick_a = 1'b0;
    check("a_slot2_active", 32'(en_a), 32'h4);
    for (int i = 0; i < 599; i++) begin
      tick_a = 1'b1;
      cyc();
    end
    tick_a = 1'b0;
    check("a_life_pre", 32'(en_a), 32'h4);
    tick_a = 1'b1;
    cyc();
    tick_a = 1'b0;
    check("a_life_expire_en", 32'(en_a), 0);
    check("a_life_expire_live", 32'(live_a), 0);

    // Round-robin with all requests held, no cooldown
    rst_b = 1'b0;
    cyc();
    for (int i = 0; i < 8; i++) begin
      rx_b[11*i +: 11] = 11'(10 * i + 1);
      ry_b[11*i +: 11] = 11'(20 * i + 2);
    end
    req_b = 8'hFF;
    for (int k = 0; k < 4; k++) q_b.push_back(8'(1 << k));
    for (int k = 0; k < 4; k++) begin
      cyc();
      check("b_rr_seq", 32'(gnt_b), 32'(1 << k));
    end
    cyc();
    check("b_rr_stall", 32'(gnt_b), 0);
    check("b_rr_live4", 32'(live_b), 4);
    check("b_slot2_x", 32'(sx_b[32:22]), 21);
    tick_b = 1'b1;
    cyc();
    tick_b = 1'b0;
    check("b_all_active", 32'(en_b), 32'hF);
    done_b = 4'b0001;
    q_b.push_back(8'h10);
    cyc();
    done_b = 4'b0000;
    check("b_retire_en", 32'(en_b), 32'hE);
    check("b_retire_nognt", 32'(gnt_b), 0);
    cyc();
    check("b_gnt_req4", 32'(gnt_b), 32'h10);

    // Grant in the same cycle as another slot's retire
    done_b = 4'b0010;
    cyc();
    done_b = 4'b0100;
    q_b.push_back(8'h20);
    q_b.push_back(8'h40);
    cyc();
    done_b = 4'b0000;
    check("b_gnt_req5", 32'(gnt_b), 32'h20);
    check("b_slot1_x", 32'(sx_b[21:11]), 51);
    check("b_retiring_untouched", 32'(sx_b[32:22]), 21);
    check("b_en_mix", 32'(en_b), 32'h8);
    cyc();
    check("b_gnt_req6", 32'(gnt_b), 32'h40);
    check("b_slot2_x_new", 32'(sx_b[32:22]), 61);
    check("b_live_full", 32'(live_b), 4);

    // Reset mid-flight
    rst_b = 1'b1;
    req_b = '0;
    cyc();
    rst_b = 1'b0;
    check("b_rst_en", 32'(en_b), 0);
    check("b_rst_live", 32'(live_b), 0);
    check("b_rst_x1", 32'(sx_b[21:11]), 0);
    req_b = 8'h20;
    q_b.push_back(8'h20);
    cyc();
    check("b_post_rst_gnt", 32'(gnt_b), 32'h20);
    check("b_post_rst_slot0_x", 32'(sx_b[10:0]), 51);
    check("b_post_rst_live", 32'(live_b), 1);
    req_b = '0;

    cyc(3);
    check("a_sb_drained", q_a.size(), 0);
    check("b_sb_drained", q_b.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/shot_scheduler.md
# shot_scheduler

Allocates a fixed pool of shot slots to fire requesters (player cannon and enemy columns) and sequences each slot's `en` line through load, flight and retire. Each slot drives one shot instance. The scheduler presents the origin coordinates and holds `en` low long enough for the shot to latch them on a movement tick. It then raises `en` and retires the slot on a hit/edge report or a lifetime timeout. It sits between the game-logic fire requests and the array of shot instances, all in the pixel-clock domain.

## Interface
- `NUM_SLOTS`, 4: shot instances managed, 1..8.
- `NUM_REQ`, 8: requesters; index 0 is the player, 1..NUM_REQ-1 are enemy columns.
- `COOLDOWN`, 3: move ticks after any grant during which no new grant is issued; 0 disables.
- `MAX_TICKS`, 600: move ticks a slot may stay ACTIVE before forced retire, ≥1.

Ports:
- `s_clk` in 1: pixel clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `move_tick` in 1: single-`s_clk` pulse coincident with each shot-movement (`clk_0`) edge.
- `req` in NUM_REQ: level fire request per requester.
- `req_x`, `req_y` in NUM_REQ*11: flattened origin per requester; requester i uses bits [11i+10:11i].
- `slot_done` in NUM_SLOTS: per-slot retire request (hit or off-screen), honoured only in ACTIVE.
- `gnt` out NUM_REQ: one-hot, one-cycle grant pulse.
- `slot_en` out NUM_SLOTS: to shot `en`.
- `slot_x`, `slot_y` out NUM_SLOTS*11: to shot `orig_x`/`orig_y`, flattened like `req_x`.
- `live_cnt` out 4: number of slots not IDLE.

## Operation
- Per-slot FSM with states IDLE, ARM and ACTIVE. `slot_en` is 1 only in ACTIVE.
  - IDLE→ARM on grant to this slot. The slot latches the owner id, `slot_x` and `slot_y` from the granted requester.
  - ARM→ACTIVE on the first `move_tick` sampled while in ARM. The shot loads its origin on that tick because `en` is still low.
  - ACTIVE→IDLE on `slot_done`, or when the life counter reaches MAX_TICKS.
  - The life counter clears on entering ACTIVE and increments on each `move_tick` in ACTIVE.
- Arbitration: at most one grant per cycle. A grant requires all of the following:
  - some IDLE slot exists; the lowest-index IDLE slot is chosen;
  - the cooldown counter is 0;
  - the requester owns no non-IDLE slot (one live shot per requester).
- Round-robin pointer over requesters. The search starts at the pointer. After a grant to i, the pointer becomes (i+1) mod NUM_REQ. With no grant, the pointer holds.
- Cooldown counter: loaded with COOLDOWN on a grant. Otherwise it decrements by 1 on `move_tick` while nonzero.
- `slot_x`/`slot_y` hold their last latched value in every state.
- `req` may stay high; the one-live-shot rule prevents re-grant until the owning slot returns to IDLE.

## Timing
- Reset values: all slots IDLE, `slot_en`=0, `slot_x`/`slot_y`=0, `gnt`=0, `live_cnt`=0, pointer=0, cooldown=0, life counters=0.
- Eligible `req` at cycle t: `gnt` pulses at t+1 and the slot is ARM at t+1.
- First `move_tick` at cycle m ≥ t+1: `slot_en`=1 from m+1.
- `slot_done` at cycle d in ACTIVE: `slot_en`=0 at d+1. The freed slot is grantable from d+1, so its earliest new `gnt` is at d+2.
- Grant and `slot_done` in the same cycle: the grant uses an already-IDLE slot and never the retiring one.
- `slot_done` during IDLE or ARM is ignored.
- `rst` mid-flight: all slots drop to IDLE and `slot_en`=0 on the next edge.
- `live_cnt` is registered and matches the slot states of the same cycle.

## Structure
- Shared package `shot_pkg` holds:
  - the `COORD_W`=11 constant;
  - the slot state encoding (IDLE=2'd0, ARM=2'd1, ACTIVE=2'd2).
- Sub-module `shot_slot_fsm`, instantiated NUM_SLOTS times. It owns the state, owner id, origin registers and life counter.
- The top module owns the arbiter, pointer, cooldown counter and `live_cnt`.

## Test plan
- Reset, then `req[0]` with (320,440): `gnt[0]` pulses one cycle later and slot 0 is ARM. `slot_en[0]` rises the cycle after the next `move_tick`, and `slot_x[0]`=320, `slot_y[0]`=440.
- `req[0]` held high after a grant: no second `gnt[0]` until `slot_done[0]`. The next `gnt[0]` comes two cycles after `slot_done[0]` once cooldown=0.
- All 8 requests held with COOLDOWN=0: grants go to 0, 1, 2, 3 on consecutive cycles. No grant follows until a slot retires. After a retire, requester 4 is granted first.
- COOLDOWN=3: the second grant happens only after the 3rd `move_tick` following the first grant.
- ACTIVE slot with no `slot_done`: it returns to IDLE with `slot_en`=0 after exactly MAX_TICKS move ticks.
- `rst` asserted with 4 live slots: next cycle all `slot_en`=0 and `live_cnt`=0. A `req[5]` after `rst` falls is granted slot 0.
